mpsoc_msi_wb_mux_timeout: RTL and testbench

Wishbone 1-master to N-slave address-decoding mux with a registered, cycle-locked slave selection.
- Returns a bus error for decode misses without involving any slave.
- A per-transfer watchdog aborts stalled slaves and errors the master.
- Sits between a CPU/DMA master port and peripheral slaves in the MSI Wishbone fabric.
- Supersedes the combinational mux where slaves may hang or the address map is sparse.

---
 rtl/mpsoc_msi_wb_mux_timeout.sv | 119 +++++++++++
 tb/tb_mpsoc_msi_wb_mux_timeout.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mpsoc_msi_wb_mux_timeout.sv
// mpsoc_msi_wb_mux_timeout: Wishbone 1:N mux with locked registered selection, decode-miss error and stall watchdog.
// Define MPSOC_MSI_WB_MUX_STATS_EN to add saturating decode/timeout error counters with a synchronous clear.
module mpsoc_msi_wb_mux_timeout #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*AW-1:0] MATCH_ADDR = '0,
  parameter logic [NUM_SLAVES*AW-1:0] MATCH_MASK = '0,
  parameter int TIMEOUT = 255,
  localparam int SW = DW/8,
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT+1) : 1,
  localparam int SLW = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1
) (
  input  logic                             wb_clk_i,
  input  logic                             wb_rst_i,
`ifdef MPSOC_MSI_WB_MUX_STATS_EN
  input  logic                             stats_clr_i,
  output logic [15:0]                      dec_err_cnt_o,
  output logic [15:0]                      tmo_err_cnt_o,
`endif
  input  logic [AW-1:0]                    wbm_adr_i,
  input  logic [DW-1:0]                    wbm_dat_i,
  input  logic [SW-1:0]                    wbm_sel_i,
  input  logic                             wbm_we_i,
  input  logic                             wbm_cyc_i,
  input  logic                             wbm_stb_i,
  input  logic [2:0]                       wbm_cti_i,
  input  logic [1:0]                       wbm_bte_i,
  output logic [DW-1:0]                    wbm_dat_o,
  output logic                             wbm_ack_o,
  output logic                             wbm_err_o,
  output logic                             wbm_rty_o,
  output logic [NUM_SLAVES-1:0][AW-1:0]    wbs_adr_o,
  output logic [NUM_SLAVES-1:0][DW-1:0]    wbs_dat_o,
  output logic [NUM_SLAVES-1:0][SW-1:0]    wbs_sel_o,
  output logic [NUM_SLAVES-1:0]            wbs_we_o,
  output logic [NUM_SLAVES-1:0]            wbs_cyc_o,
  output logic [NUM_SLAVES-1:0]            wbs_stb_o,
  output logic [NUM_SLAVES-1:0][2:0]       wbs_cti_o,
  output logic [NUM_SLAVES-1:0][1:0]       wbs_bte_o,
  input  logic [NUM_SLAVES-1:0][DW-1:0]    wbs_dat_i,
  input  logic [NUM_SLAVES-1:0]            wbs_ack_i,
  input  logic [NUM_SLAVES-1:0]            wbs_err_i,
  input  logic [NUM_SLAVES-1:0]            wbs_rty_i
);
  typedef enum logic [1:0] {IDLE, ACTIVE, DECERR, DRAIN} state_t;
  state_t state_q;
  logic [SLW-1:0] sel_q, dec_idx;
  logic [CW-1:0] cnt_q;
  logic drain_first_q;
  logic [NUM_SLAVES-1:0] match;
  logic req, act, resp, tmo, dec_ent;
  // Descending scan so the lowest matching index wins.
  always_comb begin
    match = '0;
    dec_idx = '0;
    for (int i = NUM_SLAVES-1; i >= 0; i--) begin
      match[i] = (wbm_adr_i & MATCH_MASK[i*AW+:AW]) == MATCH_ADDR[i*AW+:AW];
      if (match[i]) dec_idx = SLW'(i);
    end
  end
  assign req = wbm_cyc_i & wbm_stb_i;
  assign act = state_q == ACTIVE;
  assign resp = wbs_ack_i[sel_q] | wbs_err_i[sel_q] | wbs_rty_i[sel_q];
  assign tmo = TIMEOUT > 0 && act && req && !resp && cnt_q == CW'(TIMEOUT-1);
  assign dec_ent = state_q == IDLE && req && !(|match);
  always_comb begin
    wbs_cyc_o = '0;
    wbs_stb_o = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      wbs_cyc_o[i] = act && sel_q == SLW'(i);
      wbs_stb_o[i] = wbs_cyc_o[i] && wbm_stb_i;
    end
  end
  assign wbs_adr_o = {NUM_SLAVES{wbm_adr_i}};
  assign wbs_dat_o = {NUM_SLAVES{wbm_dat_i}};
  assign wbs_sel_o = {NUM_SLAVES{wbm_sel_i}};
  assign wbs_we_o  = {NUM_SLAVES{wbm_we_i}};
  assign wbs_cti_o = {NUM_SLAVES{wbm_cti_i}};
  assign wbs_bte_o = {NUM_SLAVES{wbm_bte_i}};
  assign wbm_dat_o = act ? wbs_dat_i[sel_q] : '0;
  assign wbm_ack_o = act & wbs_ack_i[sel_q];
  assign wbm_rty_o = act & wbs_rty_i[sel_q];
  assign wbm_err_o = (act & wbs_err_i[sel_q]) | (state_q == DECERR) |
                     ((state_q == DRAIN) & (drain_first_q | wbm_stb_i));
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      state_q <= IDLE;
      sel_q <= '0;
      cnt_q <= '0;
      drain_first_q <= 1'b0;
    end else begin
      drain_first_q <= tmo;
      cnt_q <= (TIMEOUT > 0 && act && req && !resp && !tmo) ? cnt_q + 1'b1 : '0;
      case (state_q)
        IDLE: if (req) begin
          state_q <= |match ? ACTIVE : DECERR;
          if (|match) sel_q <= dec_idx;
        end
        ACTIVE: state_q <= !wbm_cyc_i ? IDLE : tmo ? DRAIN : ACTIVE;
        DECERR: state_q <= IDLE;
        DRAIN:  if (!wbm_cyc_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
`ifdef MPSOC_MSI_WB_MUX_STATS_EN
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      dec_err_cnt_o <= '0;
      tmo_err_cnt_o <= '0;
    end else if (stats_clr_i) begin
      dec_err_cnt_o <= '0;
      tmo_err_cnt_o <= '0;
    end else begin
      if (dec_ent && ~&dec_err_cnt_o) dec_err_cnt_o <= dec_err_cnt_o + 1'b1;
      if (tmo && ~&tmo_err_cnt_o) tmo_err_cnt_o <= tmo_err_cnt_o + 1'b1;
    end
`endif
endmodule

// File: tb/tb_mpsoc_msi_wb_mux_timeout.sv
// tb_mpsoc_msi_wb_mux_timeout: directed checks of decode, locking, decode error, watchdog and async reset.
module tb_mpsoc_msi_wb_mux_timeout;
  localparam int DW = 32, AW = 32, NS = 4, SW = 4;
  localparam logic [NS*AW-1:0] MADDR = {32'h2000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [NS*AW-1:0] MMASK = {32'hFF00_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000};
  logic clk = 1'b0, rst;
  logic [AW-1:0] adr;
  logic [DW-1:0] wdat;
  logic [SW-1:0] sel;
  logic we, cyc, stb;
  logic [2:0] cti;
  logic [1:0] bte;
  logic [DW-1:0] wbm_dat_o;
  logic wbm_ack_o, wbm_err_o, wbm_rty_o;
  logic [NS-1:0][AW-1:0] wbs_adr_o;
  logic [NS-1:0][DW-1:0] wbs_dat_o;
  logic [NS-1:0][SW-1:0] wbs_sel_o;
  logic [NS-1:0] wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [NS-1:0][2:0] wbs_cti_o;
  logic [NS-1:0][1:0] wbs_bte_o;
  logic [NS-1:0][DW-1:0] wbs_dat_i;
  logic [NS-1:0] wbs_ack_i, wbs_err_i, wbs_rty_i;
`ifdef MPSOC_MSI_WB_MUX_STATS_EN
  logic stats_clr;
  logic [15:0] dec_cnt, tmo_cnt;
`endif
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  mpsoc_msi_wb_mux_timeout #(
    .DW(DW), .AW(AW), .NUM_SLAVES(NS), .MATCH_ADDR(MADDR), .MATCH_MASK(MMASK), .TIMEOUT(8)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
`ifdef MPSOC_MSI_WB_MUX_STATS_EN
    .stats_clr_i(stats_clr), .dec_err_cnt_o(dec_cnt), .tmo_err_cnt_o(tmo_cnt),
`endif
    .wbm_adr_i(adr), .wbm_dat_i(wdat), .wbm_sel_i(sel), .wbm_we_i(we),
    .wbm_cyc_i(cyc), .wbm_stb_i(stb), .wbm_cti_i(cti), .wbm_bte_i(bte),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o), .wbs_we_o(wbs_we_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i), .wbs_rty_i(wbs_rty_i)
  );

  task automatic start(input logic [AW-1:0] a);
    @(posedge clk); #1;
    adr = a; cyc = 1'b1; stb = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cyc = 1'b1; stb = 1'b1; adr = 32'h1000_0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (wbs_cyc_o !== 4'b0000) begin errors++; $display("FAIL rst_cyc got %b exp 0000", wbs_cyc_o); end
    checks++; if (wbs_stb_o !== 4'b0000) begin errors++; $display("FAIL rst_stb got %b exp 0000", wbs_stb_o); end
    checks++; if ({wbm_ack_o, wbm_err_o, wbm_rty_o} !== 3'b000) begin errors++; $display("FAIL rst_resp got %b exp 000", {wbm_ack_o, wbm_err_o, wbm_rty_o}); end
    checks++; if (wbm_dat_o !== 32'h0) begin errors++; $display("FAIL rst_dat got %h exp 0", wbm_dat_o); end
`ifdef MPSOC_MSI_WB_MUX_STATS_EN
    checks++; if (dec_cnt !== 16'd0 || tmo_cnt !== 16'd0) begin errors++; $display("FAIL rst_stats got %0d/%0d exp 0/0", dec_cnt, tmo_cnt); end
`endif
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; rst = 1'b0;
  endtask

  task automatic test_read;
    start(32'h1000_0004);
    @(negedge clk);
    checks++; if (wbs_cyc_o !== 4'b0000) begin errors++; $display("FAIL rd_latency got %b exp 0000", wbs_cyc_o); end
    @(posedge clk); @(negedge clk);
    checks++; if (wbs_cyc_o !== 4'b0010) begin errors++; $display("FAIL rd_cyc got %b exp 0010", wbs_cyc_o); end
    checks++; if (wbs_stb_o !== 4'b0010) begin errors++; $display("FAIL rd_stb got %b exp 0010", wbs_stb_o); end
    checks++; if (wbs_adr_o[1] !== 32'h1000_0004) begin errors++; $display("FAIL rd_bcast_adr got %h exp 10000004", wbs_adr_o[1]); end
    checks++; if (wbm_ack_o !== 1'b0) begin errors++; $display("FAIL rd_wait1 got %b exp 0", wbm_ack_o); end
    @(posedge clk); @(negedge clk);
    checks++; if (wbm_ack_o !== 1'b0) begin errors++; $display("FAIL rd_wait2 got %b exp 0", wbm_ack_o); end
    @(posedge clk); #1;
    wbs_ack_i[1] = 1'b1; wbs_dat_i[1] = 32'hCAFE_F00D;
    @(negedge clk);
    checks++; if (wbm_ack_o !== 1'b1) begin errors++; $display("FAIL rd_ack got %b exp 1", wbm_ack_o); end
    checks++; if (wbm_dat_o !== 32'hCAFE_F00D) begin errors++; $display("FAIL rd_dat got %h exp cafef00d", wbm_dat_o); end
    checks++; if (wbm_err_o !== 1'b0) begin errors++; $display("FAIL rd_noerr got %b exp 0", wbm_err_o); end
    @(posedge clk); #1;
    wbs_ack_i = '0; cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    checks++; if (wbs_cyc_o !== 4'b0010 || wbs_stb_o !== 4'b0000) begin errors++; $display("FAIL rd_drop_lag got %b/%b exp 0010/0000", wbs_cyc_o, wbs_stb_o); end
    @(posedge clk); @(negedge clk);
    checks++; if (wbs_cyc_o !== 4'b0000) begin errors++; $display("FAIL rd_idle got %b exp 0000", wbs_cyc_o); end
  endtask

  task automatic test_overlap_lock;
    logic s3;
    start(32'h2000_0010);
    @(negedge clk);
    s3 = wbs_cyc_o[3] | wbs_stb_o[3];
    @(posedge clk); @(negedge clk);
    s3 |= wbs_cyc_o[3] | wbs_stb_o[3];
    checks++; if (wbs_cyc_o !== 4'b0100 || wbs_stb_o !== 4'b0100) begin errors++; $display("FAIL ov_sel got %b/%b exp 0100/0100", wbs_cyc_o, wbs_stb_o); end
    @(posedge clk); #1;
    adr = 32'h1000_0000;
    @(negedge clk);
    s3 |= wbs_cyc_o[3] | wbs_stb_o[3];
    checks++; if (wbs_cyc_o !== 4'b0100) begin errors++; $display("FAIL ov_lock got %b exp 0100", wbs_cyc_o); end
    @(posedge clk); #1;
    wbs_ack_i[2] = 1'b1; wbs_dat_i[2] = 32'h0000_2222;
    @(negedge clk);
    s3 |= wbs_cyc_o[3] | wbs_stb_o[3];
    checks++; if (wbm_ack_o !== 1'b1 || wbm_dat_o !== 32'h0000_2222) begin errors++; $display("FAIL ov_ack got %b %h exp 1 00002222", wbm_ack_o, wbm_dat_o); end
    checks++; if (s3 !== 1'b0) begin errors++; $display("FAIL ov_s3_touched got %b exp 0", s3); end
    @(posedge clk); #1;
    wbs_ack_i = '0; cyc = 1'b0; stb = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_decerr;
    start(32'h8000_0000);
    @(negedge clk);
    checks++; if (wbm_err_o !== 1'b0) begin errors++; $display("FAIL de_early got %b exp 0", wbm_err_o); end
    @(posedge clk); @(negedge clk);
    checks++; if (wbm_err_o !== 1'b1) begin errors++; $display("FAIL de_err got %b exp 1", wbm_err_o); end
    checks++; if (wbs_cyc_o !== 4'b0000) begin errors++; $display("FAIL de_cyc got %b exp 0000", wbs_cyc_o); end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    checks++; if (wbm_err_o !== 1'b0 || wbs_cyc_o !== 4'b0000) begin errors++; $display("FAIL de_pulse got %b %b exp 0 0000", wbm_err_o, wbs_cyc_o); end
`ifdef MPSOC_MSI_WB_MUX_STATS_EN
    checks++; if (dec_cnt !== 16'd1) begin errors++; $display("FAIL de_stats got %0d exp 1", dec_cnt); end
`endif
  endtask

  task automatic test_timeout;
    start(32'h0000_0000);
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++; if (wbm_err_o !== 1'b0 || wbs_cyc_o !== 4'b0001) begin errors++; $display("FAIL to_wait%0d got %b %b exp 0 0001", k, wbm_err_o, wbs_cyc_o); end
      @(posedge clk);
    end
    @(negedge clk);
    checks++; if (wbm_err_o !== 1'b1) begin errors++; $display("FAIL to_err got %b exp 1", wbm_err_o); end
    checks++; if (wbs_cyc_o !== 4'b0000) begin errors++; $display("FAIL to_abort got %b exp 0000", wbs_cyc_o); end
    @(posedge clk); #1;
    wbs_ack_i[0] = 1'b1;
    @(negedge clk);
    checks++; if (wbm_ack_o !== 1'b0 || wbm_err_o !== 1'b1) begin errors++; $display("FAIL to_late_ack got %b %b exp 0 1", wbm_ack_o, wbm_err_o); end
    @(posedge clk); #1;
    stb = 1'b0;
    @(negedge clk);
    checks++; if (wbm_ack_o !== 1'b0 || wbm_err_o !== 1'b0 || wbs_cyc_o !== 4'b0000) begin errors++; $display("FAIL to_drain_idle got %b %b %b exp 0 0 0000", wbm_ack_o, wbm_err_o, wbs_cyc_o); end
`ifdef MPSOC_MSI_WB_MUX_STATS_EN
    checks++; if (tmo_cnt !== 16'd1) begin errors++; $display("FAIL to_stats got %0d exp 1", tmo_cnt); end
`endif
    @(posedge clk); #1;
    cyc = 1'b0; wbs_ack_i = '0;
    @(posedge clk);
  endtask

  task automatic test_ack_at_limit;
    start(32'h0000_0000);
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      #1;
      if (k == 7) wbs_ack_i[0] = 1'b1;
      @(negedge clk);
      checks++; if (wbm_ack_o !== (k == 7) || wbm_err_o !== 1'b0) begin errors++; $display("FAIL lim_c%0d got ack %b err %b exp %b 0", k, wbm_ack_o, wbm_err_o, k == 7); end
      @(posedge clk);
    end
    #1;
    wbs_ack_i = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++; if (wbm_err_o !== 1'b0 || wbs_cyc_o !== 4'b0001) begin errors++; $display("FAIL lim_clear%0d got %b %b exp 0 0001", k, wbm_err_o, wbs_cyc_o); end
      @(posedge clk);
    end
    @(negedge clk);
    checks++; if (wbm_err_o !== 1'b1) begin errors++; $display("FAIL lim_refire got %b exp 1", wbm_err_o); end
`ifdef MPSOC_MSI_WB_MUX_STATS_EN
    checks++; if (tmo_cnt !== 16'd2) begin errors++; $display("FAIL lim_stats got %0d exp 2", tmo_cnt); end
`endif
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_async_reset;
    start(32'h1000_0000);
    @(posedge clk); #1;
    wbs_ack_i[1] = 1'b1; wbs_dat_i[1] = 32'h1234_5678;
    @(negedge clk);
    checks++; if (wbm_ack_o !== 1'b1 || wbm_dat_o !== 32'h1234_5678) begin errors++; $display("FAIL ar_pre got %b %h exp 1 12345678", wbm_ack_o, wbm_dat_o); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (wbs_cyc_o !== 4'b0000 || wbs_stb_o !== 4'b0000) begin errors++; $display("FAIL ar_slave got %b %b exp 0000 0000", wbs_cyc_o, wbs_stb_o); end
    checks++; if ({wbm_ack_o, wbm_err_o, wbm_rty_o} !== 3'b000 || wbm_dat_o !== 32'h0) begin errors++; $display("FAIL ar_master got %b %h exp 000 0", {wbm_ack_o, wbm_err_o, wbm_rty_o}, wbm_dat_o); end
`ifdef MPSOC_MSI_WB_MUX_STATS_EN
    checks++; if (dec_cnt !== 16'd0 || tmo_cnt !== 16'd0) begin errors++; $display("FAIL ar_stats got %0d/%0d exp 0/0", dec_cnt, tmo_cnt); end
`endif
    @(posedge clk); #1;
    rst = 1'b0; wbs_ack_i = '0; adr = 32'h2000_0010;
    @(negedge clk);
    checks++; if (wbs_cyc_o !== 4'b0000) begin errors++; $display("FAIL ar_idle got %b exp 0000", wbs_cyc_o); end
    @(posedge clk); @(negedge clk);
    checks++; if (wbs_cyc_o !== 4'b0100) begin errors++; $display("FAIL ar_fresh got %b exp 0100", wbs_cyc_o); end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst = 1'b1; adr = '0; wdat = 32'h5A5A_A5A5; sel = 4'hF; we = 1'b0;
    cyc = 1'b0; stb = 1'b0; cti = 3'b000; bte = 2'b00;
    wbs_dat_i = '0; wbs_ack_i = '0; wbs_err_i = '0; wbs_rty_i = '0;
`ifdef MPSOC_MSI_WB_MUX_STATS_EN
    stats_clr = 1'b0;
`endif
    test_reset;
    test_read;
    test_overlap_lock;
    test_decerr;
    test_timeout;
    test_ack_at_limit;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
